// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode constants, PC increment and PC sequencer state type
package riscv_pkg;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [31:0] PC_INC     = 32'd4;
   typedef logic [0:0] pc_seq_state_t;
   localparam pc_seq_state_t RUN  = 1'b0;
   localparam pc_seq_state_t PEND = 1'b1;
endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel: redirect priority, target alignment or trap (PC_SEQ_MISALIGN_TRAP_EN), flush vector
module pc_redirect_sel
   import riscv_pkg::*;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
#(
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
)
`endif
(
   input  logic        en_i,
   input  logic        pend_i,
   input  logic        br_taken_ex_i,
   input  logic [31:0] br_target_ex_i,
   input  logic        jalr_valid_mem_i,
   input  logic [31:0] jalr_target_mem_i,
   output logic        redirect_o,
   output logic [31:0] target_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        ex_mem_flush_o,
   output logic        misalign_o
);
   logic        take_mem;
   logic        take_ex;
   logic [31:0] raw;
   // an EX branch seen while a redirect is pending is younger and gets flushed
   assign take_mem       = en_i && jalr_valid_mem_i;
   assign take_ex        = en_i && br_taken_ex_i && !pend_i;
   assign redirect_o     = take_mem || take_ex;
   assign raw            = take_mem ? jalr_target_mem_i : br_target_ex_i;
   assign if_id_flush_o  = redirect_o;
   assign id_ex_flush_o  = redirect_o;
   assign ex_mem_flush_o = take_mem;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   assign misalign_o     = redirect_o && (raw[1:0] != 2'b00);
   assign target_o       = misalign_o ? TRAP_VECTOR : raw;
`else
   assign misalign_o     = 1'b0;
   assign target_o       = raw & ~32'd3;
`endif
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage fetch PC sequencer with buffered redirects; PC_SEQ_MISALIGN_TRAP_EN enables misaligned-target trap
module pc_sequencer
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   ,parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_write_i,
   input  logic        imem_ready_i,
   input  logic        br_taken_ex_i,
   input  logic [31:0] br_target_ex_i,
   input  logic        jalr_valid_mem_i,
   input  logic [31:0] jalr_target_mem_i,
   output logic [31:0] pc_o,
   output logic        if_valid_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        ex_mem_flush_o,
   output logic        misalign_o,
   output logic [15:0] redirect_cnt_o
);
   pc_seq_state_t state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          redirect;
   logic [31:0]   target;
   pc_redirect_sel
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   #(.TRAP_VECTOR(TRAP_VECTOR))
`endif
   u_sel (
      .en_i              (reset),
      .pend_i            (state_q == PEND),
      .br_taken_ex_i     (br_taken_ex_i),
      .br_target_ex_i    (br_target_ex_i),
      .jalr_valid_mem_i  (jalr_valid_mem_i),
      .jalr_target_mem_i (jalr_target_mem_i),
      .redirect_o        (redirect),
      .target_o          (target),
      .if_id_flush_o     (if_id_flush_o),
      .id_ex_flush_o     (id_ex_flush_o),
      .ex_mem_flush_o    (ex_mem_flush_o),
      .misalign_o        (misalign_o)
   );
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      if (state_q == PEND) begin
         pend_pc_d = redirect ? target : pend_pc_q;
         if (imem_ready_i) begin
            pc_d    = pend_pc_d;
            state_d = RUN;
         end
      end else if (redirect) begin
         if (imem_ready_i) begin
            pc_d = target;
         end else begin
            pend_pc_d = target;
            state_d   = PEND;
         end
      end else if (imem_ready_i && pc_write_i) begin
         pc_d = pc_q + PC_INC;
      end
   end
   assign cnt_d = (redirect && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'h0;
         cnt_q     <= 16'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         cnt_q     <= cnt_d;
      end
   end
   assign pc_o           = pc_q;
   assign if_valid_o     = reset && (state_q == RUN) && !redirect;
   assign redirect_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer against a pending-target reference model
module tb_pc_sequencer;
   logic        clk;
   logic        reset;
   logic        pc_write_i;
   logic        imem_ready_i;
   logic        br_taken_ex_i;
   logic [31:0] br_target_ex_i;
   logic        jalr_valid_mem_i;
   logic [31:0] jalr_target_mem_i;
   logic [31:0] pc_o;
   logic        if_valid_o;
   logic        if_id_flush_o;
   logic        id_ex_flush_o;
   logic        ex_mem_flush_o;
   logic        misalign_o;
   logic [15:0] redirect_cnt_o;
   pc_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .pc_write_i        (pc_write_i),
      .imem_ready_i      (imem_ready_i),
      .br_taken_ex_i     (br_taken_ex_i),
      .br_target_ex_i    (br_target_ex_i),
      .jalr_valid_mem_i  (jalr_valid_mem_i),
      .jalr_target_mem_i (jalr_target_mem_i),
      .pc_o              (pc_o),
      .if_valid_o        (if_valid_o),
      .if_id_flush_o     (if_id_flush_o),
      .id_ex_flush_o     (id_ex_flush_o),
      .ex_mem_flush_o    (ex_mem_flush_o),
      .misalign_o        (misalign_o),
      .redirect_cnt_o    (redirect_cnt_o)
   );
   typedef struct {
      logic [31:0] pc;
      logic        v, f1, f2, f3, m;
      logic [15:0] c;
   } exp_t;
   exp_t        sb[$];
   exp_t        cur;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_pc  = 32'h0;
   bit          m_pend = 0;
   logic [31:0] m_tgt = 32'h0;
   int          m_cnt = 0;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
      tests++;
      if (a !== b) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, b, $time);
      end
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         chk("pc_o", pc_o, cur.pc);
         chk("if_valid_o", {31'b0, if_valid_o}, {31'b0, cur.v});
         chk("if_id_flush_o", {31'b0, if_id_flush_o}, {31'b0, cur.f1});
         chk("id_ex_flush_o", {31'b0, id_ex_flush_o}, {31'b0, cur.f2});
         chk("ex_mem_flush_o", {31'b0, ex_mem_flush_o}, {31'b0, cur.f3});
         chk("misalign_o", {31'b0, misalign_o}, {31'b0, cur.m});
         chk("redirect_cnt_o", {16'b0, redirect_cnt_o}, {16'b0, cur.c});
      end
   end
   // Model: an accepted redirect becomes a pending target, applied on the first ready edge.
   task automatic step(input bit rs, input bit pw, input bit rd, input bit br, input logic [31:0] bt,
                       input bit jv, input logic [31:0] jt);
      exp_t        e;
      bit          tm, te, acc, mis;
      logic [31:0] raw, tgt;
      @(posedge clk);
      #1;
      reset = rs; pc_write_i = pw; imem_ready_i = rd;
      br_taken_ex_i = br; br_target_ex_i = bt;
      jalr_valid_mem_i = jv; jalr_target_mem_i = jt;
      e.pc = m_pc;
      e.c  = m_cnt[15:0];
      if (!rs) begin
         e.v = 0; e.f1 = 0; e.f2 = 0; e.f3 = 0; e.m = 0;
         sb.push_back(e);
         m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0; m_cnt = 0;
         return;
      end
      tm  = jv;
      te  = br && !m_pend;
      acc = tm || te;
      raw = tm ? jt : bt;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      mis = acc && (raw % 4 != 0);
      tgt = mis ? 32'h100 : raw;
`else
      mis = 0;
      tgt = raw - (raw % 4);
`endif
      e.v = !m_pend && !acc; e.f1 = acc; e.f2 = acc; e.f3 = tm; e.m = mis;
      sb.push_back(e);
      if (acc) begin
         m_pend = 1;
         m_tgt  = tgt;
         m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end
      if (m_pend) begin
         if (rd) begin
            m_pc   = m_tgt;
            m_pend = 0;
         end
      end else if (rd && pw) begin
         m_pc = m_pc + 32'd4;
      end
   endtask
   function automatic logic [31:0] rnd_tgt();
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
      return t;
   endfunction
   initial begin
      reset = 0; pc_write_i = 0; imem_ready_i = 0;
      br_taken_ex_i = 0; br_target_ex_i = 0; jalr_valid_mem_i = 0; jalr_target_mem_i = 0;
      @(posedge clk);
      step(0, 1, 1, 0, 0, 0, 0);
      repeat (2) step(1, 1, 1, 0, 0, 0, 0);
      repeat (3) step(1, 0, 1, 0, 0, 0, 0);
      repeat (3) step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h40, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h80, 1, 32'h200);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 1, 32'h300);
      step(1, 1, 0, 1, 32'h500, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h42, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 1, 32'h600);
      step(1, 1, 0, 0, 0, 1, 32'h700);
      step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1, 32'hFFFF_FFF8);
      repeat (3) step(1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 1, 32'h900);
      step(0, 1, 0, 0, 0, 0, 0);
      repeat (3) step(1, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, rnd_tgt(), $urandom_range(0, 9) == 0, rnd_tgt());
      repeat (2) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d entries left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
